clock_set_ctrl: RTL

User-interface controller that sequences the digital clock's time-setting datapath. Debounces the three front-panel buttons (mode, increment, zero) and runs a RUN / SET_HOUR / SET_MIN mode machine. Emits the one-cycle `set_en`/`set_mp`/`set_hp`/`set_clr` strobes consumed by the time-setting counter, plus the run enable and field-blink flags for the display. Sits between the board button pins and the time counter/display mux.

---
 rtl/clock_ctrl_pkg.sv | 17 +
 rtl/btn_debounce.sv | 61 ++++++
 rtl/clock_set_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Mode encodings shared by the time-setting controller and the display mux.
package clock_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_BAD      = 2'd3
    } mode_t;

    function automatic logic is_set_mode(input mode_t m);
        return (m == MODE_SET_HOUR) || (m == MODE_SET_MIN);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button conditioner: 2-flop synchronizer, sample-gated debouncer
// and a one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CNT = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic samp,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CNT + 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          level_d_r;

    // Bring the raw pin into the clk domain
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    // Level flips only after DEB_CNT consecutive differing samples
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (samp) begin
            if (sync_r[1] != level_r) begin
                if (cnt_r == CW'(DEB_CNT - 1)) begin
                    cnt_r   <= '0;
                    level_r <= ~level_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Delayed level for edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_r;
        end
    end

    assign level = level_r;
    assign press = level_r & ~level_d_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting UI controller: RUN / SET_HOUR / SET_MIN mode machine with
// auto-repeat, idle timeout and field blink, driving one-cycle set strobes.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEB_CNT    = 20,
    parameter int REP_DELAY  = 500,
    parameter int REP_RATE   = 100,
    parameter int IDLE_TO    = 10000,
    parameter int BLINK_HALF = 250
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              samp,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_zero,
    output logic              run_en,
    output logic              set_en,
    output logic              set_mp,
    output logic              set_hp,
    output logic              set_clr,
    output logic [MODE_W-1:0] mode,
    output logic              blink_h,
    output logic              blink_m
);

    localparam int RCW = $clog2(REP_DELAY + 1);
    localparam int ICW = $clog2(IDLE_TO + 1);
    localparam int BCW = $clog2(BLINK_HALF + 1);

    mode_t          state_r, state_s;
    logic           mode_press_s, inc_press_s, zero_press_s, inc_lvl_s;
    logic           mode_lvl_unused, zero_lvl_unused;
    logic           in_set_s, mode_chg_s, zero_evt_s, inc_evt_s;
    logic           rep_pulse_s, activity_s, idle_hit_s;
    logic [RCW-1:0] rep_cnt_r;
    logic [ICW-1:0] idle_cnt_r;
    logic [BCW-1:0] blink_cnt_r, blink_cnt_s;
    logic           phase_r, phase_s;
    logic           run_en_s, set_mp_s, set_hp_s, set_clr_s, blink_h_s, blink_m_s;
    logic           run_en_r, set_en_r, set_mp_r, set_hp_r, set_clr_r, blink_h_r, blink_m_r;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
        .clk(clk), .clr(clr), .samp(samp), .btn(btn_mode),
        .level(mode_lvl_unused), .press(mode_press_s)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_inc (
        .clk(clk), .clr(clr), .samp(samp), .btn(btn_inc),
        .level(inc_lvl_s), .press(inc_press_s)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_zero (
        .clk(clk), .clr(clr), .samp(samp), .btn(btn_zero),
        .level(zero_lvl_unused), .press(zero_press_s)
    );

    // Priority: mode press drops zero/inc, zero press drops inc/repeat
    assign in_set_s    = is_set_mode(state_r);
    assign rep_pulse_s = samp & in_set_s & inc_lvl_s & (rep_cnt_r == RCW'(REP_DELAY - 1));
    assign zero_evt_s  = in_set_s & zero_press_s & ~mode_press_s;
    assign inc_evt_s   = in_set_s & (inc_press_s | rep_pulse_s) & ~mode_press_s & ~zero_press_s;
    assign activity_s  = mode_press_s | inc_press_s | zero_press_s | rep_pulse_s;
    assign idle_hit_s  = samp & in_set_s & ~activity_s & (idle_cnt_r == ICW'(IDLE_TO - 1));
    assign mode_chg_s  = (state_s != state_r);

    // Mode state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= MODE_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Mode next-state: mode press steps, idle timeout falls back to RUN
    always_comb begin
        state_s = state_r;
        case (state_r)
            MODE_RUN:      state_s = mode_press_s ? MODE_SET_HOUR : MODE_RUN;
            MODE_SET_HOUR: state_s = mode_press_s ? MODE_SET_MIN :
                                     (idle_hit_s ? MODE_RUN : MODE_SET_HOUR);
            MODE_SET_MIN:  state_s = (mode_press_s | idle_hit_s) ? MODE_RUN : MODE_SET_MIN;
            default:       state_s = MODE_RUN;
        endcase
    end

    // Blink phase restarts visible on every mode change
    always_comb begin
        phase_s     = phase_r;
        blink_cnt_s = blink_cnt_r;
        if (mode_chg_s || !in_set_s) begin
            phase_s     = 1'b0;
            blink_cnt_s = '0;
        end else if (samp) begin
            if (blink_cnt_r == BCW'(BLINK_HALF - 1)) begin
                blink_cnt_s = '0;
                phase_s     = ~phase_r;
            end else begin
                blink_cnt_s = blink_cnt_r + BCW'(1);
            end
        end else begin
            phase_s     = phase_r;
            blink_cnt_s = blink_cnt_r;
        end
    end

    // Output decode from the next state so mode, run_en and blink move together
    always_comb begin
        run_en_s  = (state_s == MODE_RUN);
        set_hp_s  = inc_evt_s & (state_r == MODE_SET_HOUR);
        set_mp_s  = inc_evt_s & (state_r == MODE_SET_MIN);
        set_clr_s = zero_evt_s;
        blink_h_s = (state_s == MODE_SET_HOUR) & phase_s;
        blink_m_s = (state_s == MODE_SET_MIN) & phase_s;
    end

    // Repeat, idle and blink counters; repeat re-arms REP_RATE below the pulse point
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rep_cnt_r   <= '0;
            idle_cnt_r  <= '0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else begin
            if (!in_set_s || !inc_lvl_s || mode_chg_s || zero_evt_s) begin
                rep_cnt_r <= '0;
            end else if (samp) begin
                rep_cnt_r <= rep_pulse_s ? RCW'(REP_DELAY - REP_RATE) : rep_cnt_r + RCW'(1);
            end
            if (!in_set_s || activity_s || mode_chg_s) begin
                idle_cnt_r <= '0;
            end else if (samp) begin
                idle_cnt_r <= idle_cnt_r + ICW'(1);
            end
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            run_en_r  <= 1'b0;
            set_en_r  <= 1'b0;
            set_mp_r  <= 1'b0;
            set_hp_r  <= 1'b0;
            set_clr_r <= 1'b0;
            blink_h_r <= 1'b0;
            blink_m_r <= 1'b0;
        end else begin
            run_en_r  <= run_en_s;
            set_en_r  <= set_mp_s | set_hp_s;
            set_mp_r  <= set_mp_s;
            set_hp_r  <= set_hp_s;
            set_clr_r <= set_clr_s;
            blink_h_r <= blink_h_s;
            blink_m_r <= blink_m_s;
        end
    end

    assign run_en  = run_en_r;
    assign set_en  = set_en_r;
    assign set_mp  = set_mp_r;
    assign set_hp  = set_hp_r;
    assign set_clr = set_clr_r;
    assign mode    = state_r;
    assign blink_h = blink_h_r;
    assign blink_m = blink_m_r;

endmodule
